// File: rtl/spi_adc_if.sv
// Bus bundle between the acquisition host and spi_adc_ctrl.
// master = host / board side, slave = the controller.
interface spi_adc_if #(
  parameter int DATA_W = 14,
  parameter int NUM_CH = 2,
  parameter int GAIN_W = 4
);
  logic                       start;
  logic                       continuous;
  logic                       gain_load;
  logic [NUM_CH*GAIN_W-1:0]   gain_word;
  logic                       data_ready;
  logic                       spi_miso;
  logic                       spi_sck;
  logic                       spi_mosi;
  logic                       amp_cs;
  logic                       amp_shdn;
  logic                       adc_conv;
  logic                       busy;
  logic                       data_valid;
  logic [NUM_CH*DATA_W-1:0]   data_out;
  logic                       overrun;

  modport master (
    output start, continuous, gain_load, gain_word, data_ready, spi_miso,
    input  spi_sck, spi_mosi, amp_cs, amp_shdn, adc_conv, busy,
           data_valid, data_out, overrun
  );

  modport slave (
    input  start, continuous, gain_load, gain_word, data_ready, spi_miso,
    output spi_sck, spi_mosi, amp_cs, amp_shdn, adc_conv, busy,
           data_valid, data_out, overrun
  );
endinterface

// File: rtl/spi_adc_ctrl.sv
// SPI sequencer for a programmable preamp plus simultaneous-sampling ADC.
// Optional macro SPI_ADC_FRAME_CNT_EN adds a 16-bit frame counter output.
//
// state     | meaning
// S_IDLE    | waiting for start or a pending gain update
// S_G_CS    | preamp chip select asserted
// S_G_SHIFT | gain word shifted out MSB first, two ticks per bit
// S_G_END   | sck parked low, amp_cs released on exit
// S_CONV    | adc_conv strobe high for one tick
// S_C_WAIT  | two ticks of conversion time
// S_A_SHIFT | ADC frame clocked in, sampled on sck falling
// S_DONE    | frame handed to the output register
// S_GAP     | CONV_GAP idle ticks before the next decision
module spi_adc_ctrl #(
  parameter int CLK_DIV  = 25,
  parameter int DATA_W   = 14,
  parameter int NUM_CH   = 2,
  parameter int PAD_BITS = 2,
  parameter int GAIN_W   = 4,
  parameter int CONV_GAP = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef SPI_ADC_FRAME_CNT_EN
  output logic [15:0] frame_cnt_o,
`endif
  spi_adc_if.slave    bus
);

  localparam int NG    = NUM_CH * GAIN_W;
  localparam int SLOT  = DATA_W + PAD_BITS;
  localparam int FRAME = NUM_CH * SLOT + PAD_BITS;
  localparam int AW    = NUM_CH * DATA_W;
  localparam int CMAX0 = (2 * FRAME > 2 * NG) ? 2 * FRAME : 2 * NG;
  localparam int CMAX  = (CMAX0 > CONV_GAP) ? CMAX0 : CONV_GAP;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int SP_W  = $clog2(SLOT + 1);
  localparam int GI_W  = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_G_CS, S_G_SHIFT, S_G_END, S_CONV,
    S_C_WAIT, S_A_SHIFT, S_DONE, S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         tick_cnt_q;
  logic               tick;

  logic [NG-1:0]      gain_q;
  logic [NG-1:0]      gsh_q;
  logic               gain_pend_q;
  logic               conv_req_q;
  logic [AW-1:0]      abuf_q;
  logic [SP_W-1:0]    slot_pos_q;
  logic [AW-1:0]      frame_w;

  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               conv_q, conv_d;
  logic               dv_q;
  logic [AW-1:0]      dout_q;
  logic               ovr_q;

  logic               done_evt;
  logic               accept;
  logic               sample;

  assign tick     = (tick_cnt_q == 8'(CLK_DIV - 1));
  assign done_evt = tick && (state_q == S_DONE);
  assign accept   = dv_q && bus.data_ready;
  assign sample   = tick && (state_q == S_A_SHIFT) && !cnt_q[0] &&
                    (cnt_q >= CNT_W'(2 * PAD_BITS));

  // ch0 arrives first on the wire but belongs in the LSBs of data_out
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign frame_w[c*DATA_W +: DATA_W] = abuf_q[(NUM_CH-1-c)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (gain_pend_q)     state_d = S_G_CS;
          else if (conv_req_q) state_d = S_CONV;
        end
        S_G_CS: begin
          cnt_d   = '0;
          state_d = S_G_SHIFT;
        end
        S_G_SHIFT: begin
          if (cnt_q == CNT_W'(2 * NG - 1)) begin
            cnt_d   = '0;
            state_d = S_G_END;
          end
        end
        S_G_END: begin
          cnt_d   = '0;
          state_d = conv_req_q ? S_CONV : S_IDLE;
        end
        S_CONV: begin
          cnt_d   = '0;
          state_d = S_C_WAIT;
        end
        S_C_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_A_SHIFT;
          end
        end
        S_A_SHIFT: begin
          if (cnt_q == CNT_W'(2 * FRAME - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(CONV_GAP - 1)) begin
            cnt_d = '0;
            if (gain_pend_q)         state_d = S_G_CS;
            else if (bus.continuous) state_d = S_CONV;
            else                     state_d = S_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the next state and registered, so pins only move on tick edges
  always_comb begin
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    cs_d   = 1'b1;
    conv_d = 1'b0;
    unique case (state_d)
      S_G_CS:    cs_d = 1'b0;
      S_G_SHIFT: begin
        cs_d   = 1'b0;
        sck_d  = cnt_d[0];
        mosi_d = gsh_q[GI_W'(NG - 1) - cnt_d[GI_W:1]];
      end
      S_G_END:   cs_d = 1'b0;
      S_CONV:    conv_d = 1'b1;
      S_A_SHIFT: sck_d = ~cnt_d[0];
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q  <= '0;
      gain_q      <= {NUM_CH{GAIN_W'(1)}};
      gsh_q       <= '0;
      gain_pend_q <= 1'b0;
      conv_req_q  <= 1'b0;
      abuf_q      <= '0;
      slot_pos_q  <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
      conv_q      <= 1'b0;
      dv_q        <= 1'b0;
      dout_q      <= '0;
      ovr_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? 8'd0 : tick_cnt_q + 8'd1;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      conv_q     <= conv_d;

      if (bus.gain_load) begin
        gain_q      <= bus.gain_word;
        gain_pend_q <= 1'b1;
      end else if (tick && state_q == S_G_END) begin
        gain_pend_q <= 1'b0;
      end

      if (tick && state_d == S_G_CS)
        gsh_q <= bus.gain_load ? bus.gain_word : gain_q;

      // A gain detour out of GAP must still resume continuous conversion afterwards
      if (tick && state_d == S_CONV)
        conv_req_q <= 1'b0;
      else if (state_q == S_IDLE && bus.start)
        conv_req_q <= 1'b1;
      else if (tick && state_q == S_GAP && state_d == S_G_CS)
        conv_req_q <= bus.continuous;

      if (state_q != S_A_SHIFT) begin
        slot_pos_q <= '0;
      end else if (sample) begin
        if (slot_pos_q < SP_W'(DATA_W))
          abuf_q <= {abuf_q[AW-2:0], bus.spi_miso};
        slot_pos_q <= (slot_pos_q == SP_W'(SLOT - 1)) ? '0 : slot_pos_q + 1'b1;
      end

      if (done_evt) begin
        dout_q <= frame_w;
        dv_q   <= 1'b1;
        ovr_q  <= accept ? 1'b0 : (dv_q ? 1'b1 : ovr_q);
      end else if (accept) begin
        dv_q  <= 1'b0;
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef SPI_ADC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         frame_cnt_q <= '0;
    else if (done_evt) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt_o = frame_cnt_q;
`endif

  assign bus.spi_sck    = sck_q;
  assign bus.spi_mosi   = mosi_q;
  assign bus.amp_cs     = cs_q;
  assign bus.amp_shdn   = 1'b0;
  assign bus.adc_conv   = conv_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_spi_adc_ctrl.sv
// Directed bench for spi_adc_ctrl at CLK_DIV=4 with a behavioural ADC and gain monitor.
module tb_spi_adc_ctrl;
  localparam int DATA_W = 14;
  localparam int NUM_CH = 2;
  localparam int PAD    = 2;
  localparam int SLOT   = DATA_W + PAD;
  localparam int FRAME  = NUM_CH * SLOT + PAD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_adc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAIN_W(4)) bus ();

`ifdef SPI_ADC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  spi_adc_ctrl #(.CLK_DIV(4)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef SPI_ADC_FRAME_CNT_EN
    .frame_cnt_o(frame_cnt),
`endif
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: one frame bit presented per sck rising edge, Z bits read as 1
  logic [13:0] ch0_v = '0, ch1_v = '0;
  logic        fr [1:FRAME];
  int          a_sck = 0;
  always @(posedge bus.spi_sck or posedge bus.adc_conv) begin
    if (bus.adc_conv) begin
      a_sck = 0;
      for (int k = 1; k <= FRAME; k++) fr[k] = 1'b1;
      for (int j = 0; j < DATA_W; j++) begin
        fr[PAD + 1 + j]        = ch0_v[DATA_W-1-j];
        fr[PAD + SLOT + 1 + j] = ch1_v[DATA_W-1-j];
      end
    end else begin
      a_sck++;
      bus.spi_miso = (a_sck <= FRAME) ? fr[a_sck] : 1'b1;
    end
  end

  logic [7:0] gbits = '0;
  int         gcnt = 0, sck_edges = 0, conv_cnt = 0, dv_rise = 0;
  time        t_rise = 0, t_fall = 0, hp_hi = 0, hp_lo = 0, t_cr = 0, conv_w = 0;
  always @(posedge bus.spi_sck) begin
    if (!bus.amp_cs) begin
      gbits = {gbits[6:0], bus.spi_mosi};
      gcnt++;
    end
    hp_lo  = $time - t_fall;
    t_rise = $time;
  end
  always @(negedge bus.spi_sck) begin
    hp_hi  = $time - t_rise;
    t_fall = $time;
  end
  always @(bus.spi_sck) sck_edges++;
  always @(posedge bus.adc_conv) begin
    conv_cnt++;
    t_cr = $time;
  end
  always @(negedge bus.adc_conv) conv_w = $time - t_cr;
  always @(posedge bus.data_valid) dv_rise++;

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_gain(input logic [7:0] w);
    bus.gain_word = w;
    bus.gain_load = 1'b1;
    @(negedge clk);
    bus.gain_load = 1'b0;
  endtask

  task automatic wait_dv(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (bus.data_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
  endtask

  int   sck0, g0, c0, dv0;

  initial begin
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.gain_load  = 1'b0;
    bus.gain_word  = '0;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state and quiet idle
    sck0 = sck_edges;
    repeat (100) @(negedge clk);
    chk("rst_sck",   bus.spi_sck, 1'b0);
    chk("rst_mosi",  bus.spi_mosi, 1'b0);
    chk("rst_cs",    bus.amp_cs, 1'b1);
    chk("rst_shdn",  bus.amp_shdn, 1'b0);
    chk("rst_conv",  bus.adc_conv, 1'b0);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_dv",    bus.data_valid, 1'b0);
    chk("rst_dout",  bus.data_out, 28'h0);
    chk("rst_ovr",   bus.overrun, 1'b0);
    chk("idle_sck_edges", sck_edges - sck0, 0);

    // gain programming from IDLE
    pulse_gain(8'h3A);
    for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
    chk("g_busy_up", bus.busy, 1'b1);
    wait_idle(300);
    chk("g_busy_down", bus.busy, 1'b0);
    chk("g_pulses", gcnt, 8);
    chk("g_bits",   gbits, 8'h3A);
    chk("g_hp_hi",  hp_hi, 40);
    chk("g_hp_lo",  hp_lo, 40);
    chk("g_cs_end", bus.amp_cs, 1'b1);
    chk("g_no_conv", conv_cnt, 0);

    // single-shot frame
    ch0_v = 14'h1ABC; ch1_v = 14'h2001;
    g0 = gcnt;
    pulse_start();
    wait_dv(1000);
    chk("s_dv",     bus.data_valid, 1'b1);
    chk("s_dout",   bus.data_out, {14'h2001, 14'h1ABC});
    chk("s_conv_w", conv_w, 40);
    chk("s_conv_n", conv_cnt, 1);
    chk("s_sck_n",  a_sck, FRAME);
    chk("s_no_gain", gcnt - g0, 0);
    repeat (20) @(negedge clk);
    chk("s_dv_hold", bus.data_valid, 1'b1);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    chk("s_dv_clr", bus.data_valid, 1'b0);
    wait_idle(200);
    chk("s_idle", bus.busy, 1'b0);

    // continuous, consumer stalled: second frame overruns
    ch0_v = 14'h0123; ch1_v = 14'h3FFE;
    c0 = conv_cnt;
    bus.continuous = 1'b1;
    pulse_start();
    wait_dv(1000);
    chk("c_f1_dout", bus.data_out, {14'h3FFE, 14'h0123});
    chk("c_f1_ovr",  bus.overrun, 1'b0);
    ch0_v = 14'h0555; ch1_v = 14'h2AAA;
    for (int i = 0; i < 1000 && !bus.overrun; i++) @(negedge clk);
    bus.continuous = 1'b0;
    chk("c_ovr",     bus.overrun, 1'b1);
    chk("c_dv",      bus.data_valid, 1'b1);
    chk("c_f2_dout", bus.data_out, {14'h2AAA, 14'h0555});
    wait_idle(400);
    chk("c_frames",  conv_cnt - c0, 2);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    chk("c_dv_clr",  bus.data_valid, 1'b0);
    chk("c_ovr_clr", bus.overrun, 1'b0);

    // gain_load inside a continuous A_SHIFT
    ch0_v = 14'h0F0F; ch1_v = 14'h1234;
    c0 = conv_cnt;
    bus.continuous = 1'b1;
    bus.data_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 500 && !(conv_cnt > c0 && a_sck >= 10); i++) @(negedge clk);
    chk("m_in_shift", a_sck >= 10, 1'b1);
    g0 = gcnt;
    pulse_gain(8'h5C);
    wait_dv(1000);
    chk("m_f1_dout", bus.data_out, {14'h1234, 14'h0F0F});
    chk("m_no_gain_mid", gcnt - g0, 0);
    ch0_v = 14'h3001; ch1_v = 14'h0002;
    for (int i = 0; i < 1000 && conv_cnt < c0 + 2; i++) @(negedge clk);
    bus.continuous = 1'b0;
    chk("m_conv2",   conv_cnt - c0, 2);
    chk("m_gain_n",  gcnt - g0, 8);
    chk("m_gain_bits", gbits, 8'h5C);
    wait_dv(1000);
    chk("m_f2_dout", bus.data_out, {14'h0002, 14'h3001});
    wait_idle(400);
    chk("m_idle", bus.busy, 1'b0);
    @(negedge clk);
    bus.data_ready = 1'b0;

    // reset in the middle of A_SHIFT
    ch0_v = 14'h1111; ch1_v = 14'h2222;
    c0 = conv_cnt;
    dv0 = dv_rise;
    pulse_start();
    for (int i = 0; i < 1000 && !(conv_cnt > c0 && a_sck >= 20); i++) @(negedge clk);
    chk("r_bit20", a_sck, 20);
    rst = 1'b1;
    #1;
    chk("r_sck",  bus.spi_sck, 1'b0);
    chk("r_cs",   bus.amp_cs, 1'b1);
    chk("r_busy", bus.busy, 1'b0);
    chk("r_dv",   bus.data_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("r_no_dv", dv_rise - dv0, 0);
    chk("r_idle",  bus.busy, 1'b0);
    ch0_v = 14'h2ABC; ch1_v = 14'h1555;
    g0 = gcnt;
    pulse_start();
    wait_dv(1000);
    chk("r_dout",    bus.data_out, {14'h1555, 14'h2ABC});
    chk("r_no_gain", gcnt - g0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
